// File: rtl/cpu_pkg.sv
// Shared CPU constants: peripheral window base, timer register offsets and TCON bit layout.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TCON_W = 3;
    localparam int unsigned PRE_W  = 16;

    localparam logic [DATA_W-1:0] PERIPH_BASE = 32'h4000_0000;

    localparam logic [3:0] TIMER_TH_OFF   = 4'h0;
    localparam logic [3:0] TIMER_TL_OFF   = 4'h4;
    localparam logic [3:0] TIMER_TCON_OFF = 4'h8;
    localparam logic [3:0] TIMER_PRE_OFF  = 4'hC;

    localparam int unsigned TCON_EN    = 0;
    localparam int unsigned TCON_IRQEN = 1;
    localparam int unsigned TCON_STAT  = 2;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the reload timer: emits one tick every (PRE+1) enabled cycles.
// Only compiled when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [PRE_W-1:0] pre_i,
    output logic             tick_o
);

    logic [PRE_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i & (cnt_q == pre_i);

    // A PRE write restarts the divider; a disabled timer freezes it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/timer_irq.sv
// Memory-mapped 32-bit reload timer with sticky level IRQ on the MEM-stage data bus.
// Optional prescaler (PRE register at 0xC) is enabled by defining TIMER_PRESCALE_EN.
module timer_irq
    import cpu_pkg::*;
#(
    parameter logic [DATA_W-1:0] BASE_ADDR = PERIPH_BASE,
    parameter logic [DATA_W-1:0] TH_RESET  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [DATA_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Hit,
    output logic              IRQ
);

    logic [DATA_W-1:0] th_q, th_d;
    logic [DATA_W-1:0] tl_q, tl_d;
    logic [TCON_W-1:0] tcon_q, tcon_d;
    logic [DATA_W-1:0] pre_rd;
    logic [3:0]        off;
    logic              wr_th, wr_tl, wr_tcon;
    logic              tick_c, count_c, ovf_c;
    logic              unused_addr_bits;

    assign Hit              = (Addr[31:4] == BASE_ADDR[31:4]);
    assign off              = {Addr[3:2], 2'b00};
    assign unused_addr_bits = ^Addr[1:0];

    assign wr_th   = MemWrite & Hit & (off == TIMER_TH_OFF);
    assign wr_tl   = MemWrite & Hit & (off == TIMER_TL_OFF);
    assign wr_tcon = MemWrite & Hit & (off == TIMER_TCON_OFF);

`ifdef TIMER_PRESCALE_EN
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             wr_pre;

    assign wr_pre = MemWrite & Hit & (off == TIMER_PRE_OFF);
    assign pre_rd = {(DATA_W-PRE_W)'(0), pre_q};

    always_comb begin
        pre_d = pre_q;
        if (wr_pre) begin
            pre_d = WriteData[PRE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    timer_prescaler u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en_i   (tcon_q[TCON_EN]),
        .clr_i  (wr_pre),
        .pre_i  (pre_q),
        .tick_o (tick_c)
    );
`else
    assign tick_c = 1'b1;
    assign pre_rd = '0;
`endif

    assign count_c = tcon_q[TCON_EN] & tick_c;
    assign ovf_c   = count_c & (tl_q == '1);

    // Hardware count/reload first, then bus writes override it.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        if (ovf_c) begin
            tl_d = th_q;
            if (tcon_q[TCON_IRQEN]) begin
                tcon_d[TCON_STAT] = 1'b1;
            end
        end else if (count_c) begin
            tl_d = tl_q + DATA_W'(1);
        end
        if (wr_th) begin
            th_d = WriteData;
        end
        if (wr_tl) begin
            tl_d              = WriteData;
            tcon_d[TCON_STAT] = tcon_q[TCON_STAT];
        end
        if (wr_tcon) begin
            tcon_d = WriteData[TCON_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q   <= TH_RESET;
            tl_q   <= '0;
            tcon_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    // Read path is combinational so a load in MEM sees the pre-edge value.
    always_comb begin
        ReadData = '0;
        if (MemRead && Hit) begin
            case (off)
                TIMER_TH_OFF:   ReadData = th_q;
                TIMER_TL_OFF:   ReadData = tl_q;
                TIMER_TCON_OFF: ReadData = {(DATA_W-TCON_W)'(0), tcon_q};
                TIMER_PRE_OFF:  ReadData = pre_rd;
                default:        ReadData = '0;
            endcase
        end
    end

    assign IRQ = tcon_q[TCON_STAT] & tcon_q[TCON_IRQEN];

endmodule
